pc_stack: RTL and testbench
===========================

PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter DEPTH, default 8, return-address stack entries; power of two, 2..64.
REQ-003 Parameter LW, default $clog2(DEPTH+1), level-count width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset; 0 = reset, 1 = normal operation.
REQ-006 Din  input  AW  absolute target address from the bus.
REQ-007 Off  input  AW  two's-complement relative offset.
REQ-008 ARload  input  1  load Din into Dout.
REQ-009 ARinc  input  1  Dout increments by 1.
REQ-010 ARrel  input  1  Dout increases by the signed value of Off.
REQ-011 Call  input  1  push Dout+1, then load Din.
REQ-012 Ret  input  1  pop the top entry into Dout.
REQ-013 ErrClr  input  1  clear the sticky error flags.
REQ-014 Dout  output  AW  current address, to memory and display.
REQ-015 Level  output  LW  number of valid stack entries.
REQ-016 Full, Empty  output  1 each  Level==DEPTH and Level==0 respectively.
REQ-017 Ovf, Unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-018 Each cycle executes exactly one command; priority is Ret > Call > ARload > ARrel > ARinc > hold.
REQ-019 Ret with !Empty: Dout <= top entry; Level decrements by 1.
REQ-020 Call with !Full: stack top <= Dout+1 (mod 2^AW); Dout <= Din; Level increments by 1.
REQ-021 ARload: Dout <= Din.
REQ-022 ARrel: Dout <= Dout+Off (mod 2^AW); no overflow indication.
REQ-023 ARinc: Dout <= Dout+1; 2^AW-1 wraps to 0.
REQ-024 Ret with Empty: Unf <= 1; Dout and Level unchanged; no lower-priority command executes that cycle.
REQ-025 Call with Full: Ovf <= 1; Dout and stack unchanged; no lower-priority command executes that cycle.
REQ-026 ErrClr clears Ovf and Unf.
REQ-027 If ErrClr and a new error occur in the same cycle, the set wins.
REQ-028 All outputs are registered or decoded from registers; command-to-Dout latency is one clock edge.
REQ-029 Full, Empty and Level reflect the post-edge state in the same cycle as Dout.
REQ-030 The stack is LIFO, indexed by Level.
REQ-031 Stack entries at or above Level are don't-care and are never observable.

Reset
REQ-032 rst low forces, immediately and independent of clk: Dout=0, Level=0, Empty=1, Full=0, Ovf=0, Unf=0.
REQ-033 Stack contents need not be cleared on reset.
REQ-034 Reset asserted mid-operation aborts any command in that cycle; no partial push or pop is retained.
REQ-035 The first edge after rst rises executes normally.

Structure
REQ-036 Package pc_stack_pkg holds the command-priority encoding (CMD_HOLD, CMD_INC, CMD_REL, CMD_LOAD, CMD_CALL, CMD_RET).
REQ-037 pc_stack_pkg holds the default AW and DEPTH constants.
REQ-038 One sub-module, ras_lifo (parameters AW, DEPTH), implements the storage array, Level counter, push/pop, Full and Empty.
REQ-039 pc_stack holds the command decode, the Dout register and the error flags.

Verification
REQ-040 Reset, then ARinc for 3 cycles -> Dout = 0,1,2,3; ARload Din=16'hFFFF then ARinc -> Dout=16'hFFFF then 16'h0000.
REQ-041 Dout=16'h0010; ARrel with Off=16'hFFFC -> Dout=16'h000C; then Off=16'h0008 -> Dout=16'h0014.
REQ-042 Dout=16'h0100; Call Din=16'h0200 -> Dout=16'h0200, Level=1; Ret -> Dout=16'h0101, Level=0, Empty=1.
REQ-043 DEPTH=8: 8 Calls -> Full=1; a 9th Call -> Ovf=1, Dout and Level unchanged; 8 Rets return addresses in reverse order; a 9th Ret -> Unf=1.
REQ-044 Ret, Call, ARload and ARinc all asserted with Level=2 -> only the pop occurs; ErrClr with a simultaneous Ret on Empty -> Unf stays 1.
REQ-045 Drive rst low between edges with Level=3 -> Dout=0 and Level=0 with no clk edge; after release, Ret -> Unf=1.

Source files
------------

// File: rtl/pc_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack_pkg
// Purpose : Shared definitions for the program-counter / return-address stack.
//           Holds the default address width and stack depth, the command
//           encoding and the priority decoder that maps the raw strobes onto
//           exactly one command per cycle.
// Revision: 1.0 - initial release
// ============================================================================
package pc_stack_pkg;

  // Default address width (bits) and return-stack depth (entries).
  localparam int DEFAULT_AW    = 16;
  localparam int DEFAULT_DEPTH = 8;

  // One command executes per cycle. The enum order is the reverse of the
  // priority order, so a larger code means a higher priority.
  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC  = 3'd1,
    CMD_REL  = 3'd2,
    CMD_LOAD = 3'd3,
    CMD_CALL = 3'd4,
    CMD_RET  = 3'd5
  } cmd_t;

  // Priority decode: Ret > Call > ARload > ARrel > ARinc > hold.
  function automatic cmd_t decode_cmd(
    input logic ret,
    input logic call,
    input logic load,
    input logic rel,
    input logic inc
  );
    cmd_t cmd;
    if (ret)       cmd = CMD_RET;
    else if (call) cmd = CMD_CALL;
    else if (load) cmd = CMD_LOAD;
    else if (rel)  cmd = CMD_REL;
    else if (inc)  cmd = CMD_INC;
    else           cmd = CMD_HOLD;
    return cmd;
  endfunction

endpackage : pc_stack_pkg
`default_nettype wire

// File: rtl/ras_lifo.sv
`default_nettype none
// ============================================================================
// Module  : ras_lifo
// Purpose : Return-address LIFO. Stores up to DEPTH addresses, indexed by
//           the level counter, and decodes Full/Empty from that counter.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset (clears the level only)
//   push       in   write push_data at index level, level + 1
//   pop        in   level - 1 (top_data is the entry being popped)
//   push_data  in   AW  address to push
//   top_data   out  AW  entry at index level-1 (don't-care when empty)
//   level      out  LW  number of valid entries
//   full       out  level == DEPTH
//   empty      out  level == 0
// Revision: 1.0 - initial release
// ============================================================================
module ras_lifo
  import pc_stack_pkg::*;
#(
  parameter int AW    = DEFAULT_AW,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  // Index width of the storage array; DEPTH is a power of two >= 2.
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_m1;
  logic          w_do_push;
  logic          w_do_pop;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

  // The caller already gates push/pop with full/empty; guard again so the
  // counter can never leave 0..DEPTH even if a caller misbehaves. Pop wins
  // if both are requested, matching the command priority of the caller.
  assign w_do_pop  = pop  && !empty;
  assign w_do_push = push && !full && !pop;

  // Top-of-stack lives at level-1. When empty this aliases entry DEPTH-1,
  // which is never consumed because pop is blocked on empty.
  assign w_level_m1 = r_level - LW'(1);
  assign top_data   = r_mem[w_level_m1[IW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
    end else if (w_do_push) begin
      r_level <= r_level + LW'(1);
    end else if (w_do_pop) begin
      r_level <= r_level - LW'(1);
    end
  end

  // Storage is not reset. A write landing while reset is asserted goes to an
  // index at or above the (zero) level, so it is never observable and no
  // partial push survives the reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_level[IW-1:0]] <= push_data;
    end
  end

endmodule : ras_lifo
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack
// Purpose : Program-address register with increment, relative branch,
//           absolute load and a call/return stack. One command per cycle,
//           selected by fixed priority; errors are sticky until cleared.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   Din     in   AW  absolute target address
//   Off     in   AW  two's-complement relative offset
//   ARload  in   load Din into Dout
//   ARinc   in   Dout + 1
//   ARrel   in   Dout + Off
//   Call    in   push Dout+1, load Din
//   Ret     in   pop top entry into Dout
//   ErrClr  in   clear Ovf/Unf (a simultaneous new error still sets)
//   Dout    out  AW  current address (registered)
//   Level   out  LW  valid stack entries
//   Full    out  Level == DEPTH
//   Empty   out  Level == 0
//   Ovf     out  sticky: Call attempted while Full
//   Unf     out  sticky: Ret attempted while Empty
// Revision: 1.0 - initial release
// ============================================================================
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int AW    = DEFAULT_AW,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] Din,
  input  logic [AW-1:0] Off,
  input  logic          ARload,
  input  logic          ARinc,
  input  logic          ARrel,
  input  logic          Call,
  input  logic          Ret,
  input  logic          ErrClr,
  output logic [AW-1:0] Dout,
  output logic [LW-1:0] Level,
  output logic          Full,
  output logic          Empty,
  output logic          Ovf,
  output logic          Unf
);

  cmd_t          w_cmd;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [AW-1:0] w_ret_addr;
  logic [AW-1:0] w_top;
  logic [AW-1:0] r_dout;
  logic          r_ovf;
  logic          r_unf;

  assign w_cmd = decode_cmd(Ret, Call, ARload, ARrel, ARinc);

  // A blocked Call/Ret still consumes the cycle: it only raises its error
  // flag, and lower-priority commands are masked by the priority decode.
  assign w_push    = (w_cmd == CMD_CALL) && !Full;
  assign w_pop     = (w_cmd == CMD_RET)  && !Empty;
  assign w_ovf_set = (w_cmd == CMD_CALL) &&  Full;
  assign w_unf_set = (w_cmd == CMD_RET)  &&  Empty;

  // Return address is the instruction after the call, wrapping mod 2^AW.
  assign w_ret_addr = r_dout + AW'(1);

  ras_lifo #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_ret_addr),
    .top_data  (w_top),
    .level     (Level),
    .full      (Full),
    .empty     (Empty)
  );

  // Address register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else begin
      case (w_cmd)
        CMD_RET:  if (w_pop)  r_dout <= w_top;
        CMD_CALL: if (w_push) r_dout <= Din;
        CMD_LOAD: r_dout <= Din;
        CMD_REL:  r_dout <= r_dout + Off;
        CMD_INC:  r_dout <= r_dout + AW'(1);
        default:  r_dout <= r_dout;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle beats ErrClr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)   r_ovf <= 1'b1;
      else if (ErrClr) r_ovf <= 1'b0;

      if (w_unf_set)   r_unf <= 1'b1;
      else if (ErrClr) r_unf <= 1'b0;
    end
  end

  assign Dout = r_dout;
  assign Ovf  = r_ovf;
  assign Unf  = r_unf;

endmodule : pc_stack
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_stack
// Purpose : Directed self-checking bench for pc_stack (AW=16, DEPTH=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_stack;

  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] Din = '0;
  logic [AW-1:0] Off = '0;
  logic          ARload = 1'b0;
  logic          ARinc  = 1'b0;
  logic          ARrel  = 1'b0;
  logic          Call   = 1'b0;
  logic          Ret    = 1'b0;
  logic          ErrClr = 1'b0;
  logic [AW-1:0] Dout;
  logic [LW-1:0] Level;
  logic          Full;
  logic          Empty;
  logic          Ovf;
  logic          Unf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_stack #(.AW(AW), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .Din    (Din),
    .Off    (Off),
    .ARload (ARload),
    .ARinc  (ARinc),
    .ARrel  (ARrel),
    .Call   (Call),
    .Ret    (Ret),
    .ErrClr (ErrClr),
    .Dout   (Dout),
    .Level  (Level),
    .Full   (Full),
    .Empty  (Empty),
    .Ovf    (Ovf),
    .Unf    (Unf)
  );

  always #5 clk = ~clk;

  // Drive inputs, then advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ARload = 0; ARinc = 0; ARrel = 0; Call = 0; Ret = 0; ErrClr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    total_cnt++; if (Dout !== 16'h0000) $display("FAIL reset_dout got=%h exp=0000", Dout); else pass_cnt++;
    total_cnt++; if (Level !== 4'd0) $display("FAIL reset_level got=%0d exp=0", Level); else pass_cnt++;
    total_cnt++; if ({Empty, Full, Ovf, Unf} !== 4'b1000) $display("FAIL reset_flags got=%b exp=1000", {Empty, Full, Ovf, Unf}); else pass_cnt++;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_inc_wrap();
    logic [AW-1:0] exp;
    ARinc = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = AW'(i);
      total_cnt++; if (Dout !== exp) $display("FAIL inc_%0d got=%h exp=%h", i, Dout, exp); else pass_cnt++;
    end
    idle(); ARload = 1; Din = 16'hFFFF;
    tick();
    total_cnt++; if (Dout !== 16'hFFFF) $display("FAIL load_ffff got=%h exp=ffff", Dout); else pass_cnt++;
    idle(); ARinc = 1;
    tick();
    total_cnt++; if (Dout !== 16'h0000) $display("FAIL inc_wrap got=%h exp=0000", Dout); else pass_cnt++;
    idle();
  endtask

  task automatic test_rel();
    ARload = 1; Din = 16'h0010;
    tick();
    idle(); ARrel = 1; Off = 16'hFFFC;
    tick();
    total_cnt++; if (Dout !== 16'h000C) $display("FAIL rel_neg got=%h exp=000c", Dout); else pass_cnt++;
    Off = 16'h0008;
    tick();
    total_cnt++; if (Dout !== 16'h0014) $display("FAIL rel_pos got=%h exp=0014", Dout); else pass_cnt++;
    idle();
  endtask

  task automatic test_call_ret();
    ARload = 1; Din = 16'h0100;
    tick();
    idle(); Call = 1; Din = 16'h0200;
    tick();
    total_cnt++; if (Dout !== 16'h0200) $display("FAIL call_dout got=%h exp=0200", Dout); else pass_cnt++;
    total_cnt++; if (Level !== 4'd1) $display("FAIL call_level got=%0d exp=1", Level); else pass_cnt++;
    idle(); Ret = 1;
    tick();
    total_cnt++; if (Dout !== 16'h0101) $display("FAIL ret_dout got=%h exp=0101", Dout); else pass_cnt++;
    total_cnt++; if (Level !== 4'd0 || Empty !== 1'b1) $display("FAIL ret_level got=%0d/%b exp=0/1", Level, Empty); else pass_cnt++;
    idle();
  endtask

  task automatic test_full_empty();
    logic [AW-1:0] pushed [DEPTH];
    logic [AW-1:0] cur;
    ARload = 1; Din = 16'h1000;
    tick();
    cur = 16'h1000;
    idle(); Call = 1;
    for (int i = 0; i < DEPTH; i++) begin
      Din = 16'h2000 + AW'(i * 16);
      pushed[i] = cur + 16'h0001;
      cur = Din;
      tick();
    end
    total_cnt++; if (Full !== 1'b1 || Level !== 4'd8) $display("FAIL full got=%b/%0d exp=1/8", Full, Level); else pass_cnt++;
    Din = 16'h3000;
    tick();
    total_cnt++; if (Ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", Ovf); else pass_cnt++;
    total_cnt++; if (Dout !== 16'h2070 || Level !== 4'd8) $display("FAIL ovf_hold got=%h/%0d exp=2070/8", Dout, Level); else pass_cnt++;
    idle(); ErrClr = 1;
    tick();
    total_cnt++; if (Ovf !== 1'b0) $display("FAIL ovf_clr got=%b exp=0", Ovf); else pass_cnt++;
    idle(); Ret = 1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      tick();
      total_cnt++;
      if (Dout !== pushed[i] || Level !== LW'(i))
        $display("FAIL pop_%0d got=%h/%0d exp=%h/%0d", i, Dout, Level, pushed[i], i);
      else pass_cnt++;
    end
    tick();
    total_cnt++; if (Unf !== 1'b1 || Dout !== 16'h1001 || Level !== 4'd0) $display("FAIL unf got=%b/%h/%0d exp=1/1001/0", Unf, Dout, Level); else pass_cnt++;
    idle();
  endtask

  task automatic test_priority();
    ErrClr = 1;
    tick();
    total_cnt++; if (Unf !== 1'b0) $display("FAIL unf_clr got=%b exp=0", Unf); else pass_cnt++;
    idle(); ARload = 1; Din = 16'h0400;
    tick();
    idle(); Call = 1; Din = 16'h0500;
    tick();
    Din = 16'h0600;
    tick();
    total_cnt++; if (Level !== 4'd2 || Dout !== 16'h0600) $display("FAIL prio_setup got=%h/%0d exp=0600/2", Dout, Level); else pass_cnt++;
    Ret = 1; Call = 1; ARload = 1; ARinc = 1; Din = 16'h0700;
    tick();
    total_cnt++; if (Dout !== 16'h0501 || Level !== 4'd1) $display("FAIL prio_pop got=%h/%0d exp=0501/1", Dout, Level); else pass_cnt++;
    idle(); Ret = 1;
    tick();
    total_cnt++; if (Dout !== 16'h0401 || Empty !== 1'b1) $display("FAIL prio_pop2 got=%h/%b exp=0401/1", Dout, Empty); else pass_cnt++;
    ErrClr = 1;
    tick();
    total_cnt++; if (Unf !== 1'b1 || Dout !== 16'h0401) $display("FAIL set_beats_clr got=%b/%h exp=1/0401", Unf, Dout); else pass_cnt++;
    total_cnt++; if (Ovf !== 1'b0) $display("FAIL ovf_idle got=%b exp=0", Ovf); else pass_cnt++;
    idle();
  endtask

  task automatic test_async_reset();
    ErrClr = 1;
    tick();
    idle(); Call = 1; Din = 16'h0A00;
    repeat (3) tick();
    total_cnt++; if (Level !== 4'd3) $display("FAIL ar_setup got=%0d exp=3", Level); else pass_cnt++;
    // Mid-cycle reset with a Call still pending: no edge between assert and check.
    #2 rst = 0;
    #1;
    total_cnt++; if (Dout !== 16'h0000 || Level !== 4'd0 || Empty !== 1'b1) $display("FAIL async_rst got=%h/%0d/%b exp=0000/0/1", Dout, Level, Empty); else pass_cnt++;
    // Hold reset across an edge with Call asserted: nothing may be retained.
    tick();
    total_cnt++; if (Level !== 4'd0 || Dout !== 16'h0000) $display("FAIL rst_abort got=%h/%0d exp=0000/0", Dout, Level); else pass_cnt++;
    idle();
    @(negedge clk);
    rst = 1;
    Ret = 1;
    tick();
    total_cnt++; if (Unf !== 1'b1 || Level !== 4'd0 || Dout !== 16'h0000) $display("FAIL post_rst_unf got=%b/%0d/%h exp=1/0/0000", Unf, Level, Dout); else pass_cnt++;
    idle();
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_rel();
    test_call_ret();
    test_full_empty();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_pc_stack
`default_nettype wire
